// File: rtl/fifo_shift_ctrl_if.sv
// fifo_shift_ctrl_if: handshake bundle between operand loader, fifo lane and shift controller
interface fifo_shift_ctrl_if #(parameter int CNT_W = 16);
  logic start;
  logic [CNT_W-1:0] num_rows;
  logic abort;
  logic stall;
  logic in_valid;
  logic in_ready;
  logic fifo_en;
  logic fifo_zero;
  logic out_valid;
  logic busy;
  logic done;
  modport master (
    output start, num_rows, abort, stall, in_valid,
    input in_ready, fifo_en, fifo_zero, out_valid, busy, done
  );
  modport slave (
    input start, num_rows, abort, stall, in_valid,
    output in_ready, fifo_en, fifo_zero, out_valid, busy, done
  );
endinterface

// File: rtl/fifo_shift_ctrl.sv
// fifo_shift_ctrl: sequences one delay-fifo lane through load and zero-drain, tracking which slots hold real rows
module fifo_shift_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  fifo_shift_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] rows, load_cnt;
  logic [DW-1:0] drain_cnt;
  logic [DEPTH-1:0] vsr;
  logic last_row, last_drain;
  assign last_row = load_cnt == rows - CNT_W'(1);
  assign last_drain = drain_cnt == DW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = bus.num_rows == '0 ? DONE : LOAD;
      LOAD: if (bus.abort || (bus.fifo_en && last_row)) state_nx = DRAIN;
      DRAIN: if (bus.fifo_en && last_drain) state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end
  // abort wins over a row offered in the same cycle, so it is masked out of in_ready
  always_comb begin
    bus.in_ready = state == LOAD && !bus.stall && !bus.abort;
    bus.fifo_en = state == LOAD ? bus.in_valid && bus.in_ready : state == DRAIN && !bus.stall;
    bus.fifo_zero = state == DRAIN;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.out_valid = vsr[DEPTH-1] && bus.fifo_en;
  end
  // load count stops at the last row because LOAD is left on that accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rows <= '0;
      load_cnt <= '0;
      drain_cnt <= '0;
      vsr <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        rows <= bus.num_rows;
        load_cnt <= '0;
      end
      if (state == LOAD && bus.fifo_en) load_cnt <= load_cnt + CNT_W'(1);
      if (state == LOAD && state_nx == DRAIN) drain_cnt <= DW'(DEPTH);
      else if (state == DRAIN && bus.fifo_en) drain_cnt <= drain_cnt - DW'(1);
      if (bus.fifo_en) vsr <= (vsr << 1) | DEPTH'(state == LOAD);
    end
endmodule

// File: tb/tb_fifo_shift_ctrl.sv
// tb_fifo_shift_ctrl: cycle vectors for fifo_shift_ctrl with an out_valid arrival scoreboard
module tb_fifo_shift_ctrl;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  logic clk = 0;
  logic rst_n = 1;
  always #5 clk = ~clk;
  fifo_shift_ctrl_if #(.CNT_W(CNT_W)) bus();
  fifo_shift_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [5:0] obs;
  assign obs = {bus.in_ready, bus.fifo_en, bus.fifo_zero, bus.out_valid, bus.busy, bus.done};
  typedef struct {
    logic start;
    logic [CNT_W-1:0] n;
    logic iv, st, ab;
    logic [5:0] exp;
  } vec_t;
  vec_t vt[$];
  int sb[$];
  int nvec = 0;
  int nerr = 0;
  int gidx;
  int pat[6] = '{1, 0, 1, 1, 0, 1};
  function automatic void add(logic s, int n, logic iv, logic st, logic ab,
                              logic ir, logic en, logic z, logic ov, logic b, logic d);
    vt.push_back('{s, CNT_W'(n), iv, st, ab, {ir, en, z, ov, b, d}});
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // a row leaves the fifo on the DEPTH-th shift after the one that took it in
  function automatic int target(int i);
    int k = 0;
    for (int j = i + 1; j < vt.size(); j++)
      if (vt[j].exp[4]) begin
        k++;
        if (k == DEPTH) return j;
      end
    return -2;
  endfunction
  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bus.start = vt[i].start;
      bus.num_rows = vt[i].n;
      bus.in_valid = vt[i].iv;
      bus.stall = vt[i].st;
      bus.abort = vt[i].ab;
      if (vt[i].exp[5] && vt[i].iv) sb.push_back(target(i));
      #4;
      chk($sformatf("vec%0d {rdy,en,zero,ov,busy,done}", i), 32'(obs), 32'(vt[i].exp));
      if (obs[2]) chk($sformatf("sb_vec%0d out_valid cycle", i), i, sb.size() != 0 ? sb.pop_front() : -1);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    bus.start = 0;
    bus.num_rows = '0;
    bus.in_valid = 0;
    bus.stall = 0;
    bus.abort = 0;
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 13; c++)
      add(0, 3, c < 3, 0, 0, c < 3, c <= 10, c >= 3 && c <= 10, c >= 8 && c <= 10, c <= 11, c == 11);
    add(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 16; c++)
      add(0, 4, c < 6 && pat[c] != 0, 0, 0, c < 6, c < 6 ? pat[c] != 0 : c <= 13,
          c >= 6 && c <= 13, c >= 10 && c <= 13, c <= 14, c == 14);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 17; c++)
      add(0, 2, c < 2, c >= 4 && c <= 8, 0, c < 2, c <= 14 && !(c >= 4 && c <= 8),
          c >= 2 && c <= 14, c == 13 || c == 14, c <= 15, c == 15);
    add(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 14; c++)
      add(0, 10, c <= 3, 0, c == 3, c < 3, c < 3 || (c >= 4 && c <= 11),
          c >= 4 && c <= 11, c >= 9 && c <= 11, c <= 12, c == 12);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++)
      add(c == 1 || c == 5 || c == 10, c == 1 ? 5 : c == 5 ? 7 : c == 10 ? 3 : 2, c < 2, 0, 0,
          c < 2, c <= 9, c >= 2 && c <= 9, c == 8 || c == 9, c <= 10, c == 10);
    gidx = vt.size();
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 11; c++)
      add(0, 1, c == 0, 0, 0, c == 0, c <= 8, c >= 1 && c <= 8, c == 8, c <= 9, c == 9);
    #1 rst_n = 0;
    #1 chk("reset_outputs", 32'(obs), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    run(0, gidx);
    bus.start = 1;
    bus.num_rows = 5;
    bus.in_valid = 1;
    @(posedge clk);
    #1 bus.start = 0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("mid_load_outputs", 32'(obs), 32'(6'b110010));
    #2 rst_n = 0;
    #1 chk("async_reset_outputs", 32'(obs), 0);
    @(posedge clk);
    #1 chk("reset_held_no_done", 32'(obs), 0);
    @(negedge clk);
    rst_n = 1;
    bus.in_valid = 0;
    @(posedge clk);
    #1;
    run(gidx, vt.size());
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_shift_ctrl.md
Name: fifo_shift_ctrl

Overview:
Sequencer for one delay-buffer (fifo) lane feeding the systolic array.
- Accepts a job of N rows, gates the fifo shift enable from an upstream valid/ready stream and downstream stall, then drains DEPTH zero rows to flush the pipe.
- Tracks which fifo slots hold real data, so consumers get one pulse per valid row at q.
- Sits between the operand loader and the fifo/array edge; one instance per lane group, all sharing the fifo's DEPTH.

Parameters:
DEPTH, 8, shift latency of the controlled fifo (>=1); must equal the fifo's DEPTH.
CNT_W, 16, width of row counters and num_rows.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  job start pulse; sampled only in IDLE.
num_rows  in  CNT_W  rows in the job; latched on accepted start.
abort  in  1  in LOAD: stop accepting rows and go straight to DRAIN.
stall  in  1  downstream not ready; while high, no shift occurs.
in_valid  in  1  upstream row present on the fifo d input.
in_ready  out  1  controller accepts the row this cycle (shift with real data).
fifo_en  out  1  fifo shift enable.
fifo_zero  out  1  selects zero onto the fifo d input (drain shifts).
out_valid  out  1  the fifo q row is consumed this cycle; exactly one pulse per accepted row.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counters=0, valid-tracking register vsr[DEPTH-1:0]=0. All outputs are 0 immediately. The fifo must be reset in the same window.
- IDLE:
  - in_ready=0, fifo_en=0.
  - start & num_rows!=0 -> latch num_rows, clear load count, go to LOAD.
  - start & num_rows==0 -> DONE.
- LOAD:
  - in_ready = !stall.
  - fifo_en = in_valid & !stall; fifo_zero=0.
  - On a shift: vsr <= {vsr[DEPTH-2:0],1}, load count +1.
  - When the accepted row is row num_rows: set drain count=DEPTH, go to DRAIN.
  - abort (priority over the row accept in the same cycle; that row is not taken): set drain count=DEPTH, go to DRAIN.
- DRAIN:
  - in_ready=0, fifo_zero=1, fifo_en=!stall.
  - On a shift: vsr <= {vsr[DEPTH-2:0],0}, drain count -1.
  - When drain count reaches 0 after the shift -> DONE.
- DONE: done=1 for one cycle, busy=1, fifo_en=0; next state IDLE.
- out_valid = vsr[DEPTH-1] & fifo_en (combinational). A stalled or bubbled cycle never produces out_valid.
- Latency: with no stall or bubble, the row accepted in LOAD cycle k gives out_valid in cycle k+DEPTH.
- Job length: LOAD=N, DRAIN=DEPTH, done in cycle N+DEPTH (first LOAD cycle = 0).
- The sum of out_valid pulses per job equals the number of rows accepted (N, or fewer if aborted).
- start while busy is ignored; num_rows is not relatched.
- DEPTH=1: vsr is 1 bit; DRAIN lasts exactly 1 shift.
- Counters: load count saturates at num_rows and never wraps; num_rows = 2^CNT_W-1 is legal.
- Reset mid-job: immediate return to IDLE, no done pulse. In-flight rows are discarded and never produce out_valid.

Test Plan:
1. DEPTH=8, start with num_rows=3, in_valid=1, stall=0:
   - in_ready high in cycles 0-2.
   - out_valid in cycles 8, 9, 10.
   - fifo_zero in cycles 3-10.
   - done in cycle 11, busy low in cycle 12.
2. num_rows=4, in_valid pattern 1,0,1,1,0,1:
   - fifo_en only on the valid cycles.
   - Exactly 4 out_valid pulses, all aligned to shifts; done after 8 drain shifts.
3. num_rows=2, stall held high for 5 cycles during DRAIN:
   - No fifo_en or out_valid while stalled.
   - done is delayed by exactly 5 cycles vs scenario 1 timing.
4. num_rows=10, abort in LOAD cycle 3 with in_valid=1:
   - Only 3 rows accepted, 3 out_valid pulses.
   - DRAIN lasts 8 shifts, then done.
5. start with num_rows=0:
   - done in the next cycle, no fifo_en.
   - A start pulse asserted during a running job is ignored (num_rows unchanged).
6. rst_n dropped asynchronously mid-LOAD:
   - All outputs 0 before the next clk edge; no done pulse.
   - After release, a new job of 1 row gives a single out_valid DEPTH cycles after acceptance.
